// File: rtl/icache_ctrl.sv
// Instruction cache controller: same-cycle hits, one outstanding miss, and
// forwarding of fill data to a fetch that is still waiting on the missed block.
module icache_ctrl #(
  parameter int unsigned NUM_IDX_BITS = 5,
  parameter int unsigned NUM_TAG_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    proc2Icache_en,
  input  logic [63:0]             proc2Icache_addr,
  output logic [63:0]             Icache_data_out,
  output logic                    Icache_valid_out,
  output logic [NUM_IDX_BITS-1:0] rd1_idx,
  output logic [NUM_TAG_BITS-1:0] rd1_tag,
  input  logic [63:0]             rd1_data,
  input  logic                    rd1_valid,
  output logic                    wr1_en,
  output logic [NUM_IDX_BITS-1:0] wr1_idx,
  output logic [NUM_TAG_BITS-1:0] wr1_tag,
  output logic [63:0]             wr1_data,
  output logic [1:0]              proc2Imem_command,
  output logic [63:0]             proc2Imem_addr,
  input  logic [3:0]              Imem2proc_response,
  input  logic [63:0]             Imem2proc_data,
  input  logic [3:0]              Imem2proc_tag
);

  localparam int unsigned TagLsb = 3 + NUM_IDX_BITS;
  localparam logic [1:0] BusNone = 2'd0;
  localparam logic [1:0] BusLoad = 2'd1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                  state_q, state_d;
  logic [63:0]             miss_addr_q, miss_addr_d;
  logic [NUM_IDX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [NUM_TAG_BITS-1:0] miss_tag_q, miss_tag_d;
  logic [3:0]              mem_tag_q, mem_tag_d;
  logic                    fill;
  logic                    hit;
  logic                    fwd;
  logic                    unused_addr_offset;

  assign rd1_idx = proc2Icache_addr[3 +: NUM_IDX_BITS];
  assign rd1_tag = proc2Icache_addr[TagLsb +: NUM_TAG_BITS];
  // The byte offset never matters: lookups, misses and forwarding are per block.
  assign unused_addr_offset = ^proc2Icache_addr[2:0];

  always_comb begin
    state_d           = state_q;
    miss_addr_d       = miss_addr_q;
    miss_idx_d        = miss_idx_q;
    miss_tag_d        = miss_tag_q;
    mem_tag_d         = mem_tag_q;
    proc2Imem_command = BusNone;
    fill              = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (proc2Icache_en && !rd1_valid) begin
          miss_addr_d = {proc2Icache_addr[63:3], 3'b000};
          miss_idx_d  = rd1_idx;
          miss_tag_d  = rd1_tag;
          state_d     = StReq;
        end
      end
      StReq: begin
        proc2Imem_command = BusLoad;
        if (Imem2proc_response != 4'd0) begin
          mem_tag_d = Imem2proc_response;
          state_d   = StWait;
        end
      end
      StWait: begin
        if ((Imem2proc_tag == mem_tag_q) && (mem_tag_q != 4'd0)) begin
          fill      = 1'b1;
          mem_tag_d = 4'd0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      miss_idx_q  <= '0;
      miss_tag_q  <= '0;
      mem_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      miss_idx_q  <= miss_idx_d;
      miss_tag_q  <= miss_tag_d;
      mem_tag_q   <= mem_tag_d;
    end
  end

  assign proc2Imem_addr = miss_addr_q;
  assign wr1_en         = fill;
  assign wr1_idx        = miss_idx_q;
  assign wr1_tag        = miss_tag_q;
  assign wr1_data       = Imem2proc_data;

  // A genuine hit takes priority; forwarding only serves the block being filled.
  assign hit = proc2Icache_en && rd1_valid;
  assign fwd = fill && proc2Icache_en && (proc2Icache_addr[63:3] == miss_addr_q[63:3]);
  assign Icache_valid_out = hit || fwd;
  assign Icache_data_out  = (fwd && !hit) ? Imem2proc_data : rd1_data;

endmodule
